vga_sync_porch: RTL and testbench
=================================

VGA_SYNC_PORCH -- requirements
Module: vga_sync_porch

Interface
REQ-001 SHALL have parameter TOTAL_COLS, default 800, meaning columns per line including blanking.
REQ-002 SHALL have parameter TOTAL_ROWS, default 525, meaning lines per frame including blanking.
REQ-003 SHALL have parameter ACTIVE_COLS, default 640, meaning visible columns per line.
REQ-004 SHALL have parameter ACTIVE_ROWS, default 480, meaning visible lines per frame.
REQ-005 SHALL have parameter H_FRONT_PORCH, default 16, meaning columns from end of active video to hsync pulse.
REQ-006 SHALL have parameter H_SYNC_WIDTH, default 96, meaning hsync pulse width in columns.
REQ-007 SHALL have parameter V_FRONT_PORCH, default 10, meaning rows from end of active video to vsync pulse.
REQ-008 SHALL have parameter V_SYNC_WIDTH, default 2, meaning vsync pulse width in rows.
REQ-009 SHALL have parameter VIDEO_WIDTH, default 3, meaning bits per colour channel.
REQ-010 SHALL have port clk, input, 1 bit, meaning the pixel clock; the block has exactly one clock.
REQ-011 SHALL have port rst, input, 1 bit, meaning the reset, which is synchronous and active-high.
REQ-012 SHALL have port i_hsync, input, 1 bit, meaning the upstream active-column flag, high while the upstream column is below ACTIVE_COLS.
REQ-013 SHALL have port i_vsync, input, 1 bit, meaning the upstream active-row flag, high while the upstream row is below ACTIVE_ROWS.
REQ-014 SHALL have ports i_red, i_grn and i_blu, input, VIDEO_WIDTH bits each, meaning pixel colour aligned with i_hsync and i_vsync.
REQ-015 SHALL have ports o_hsync and o_vsync, output, 1 bit each, meaning VGA sync outputs that are active-low during the sync pulse.
REQ-016 SHALL have ports o_red, o_grn and o_blu, output, VIDEO_WIDTH bits each, meaning the delayed colour outputs.
REQ-017 SHALL have port o_locked, output, 1 bit, meaning high once internal counters are aligned to an upstream frame start.

Function
REQ-018 SHALL register i_vsync into r_vsync every cycle and detect frame start as i_vsync=1 while r_vsync=0.
REQ-019 SHALL treat the input sampled on a frame-start cycle as column 0, row 0; on that cycle the internal column counter loads 1 and the row counter loads 0.
REQ-020 SHALL otherwise advance the column counter by 1 per cycle, wrap it at TOTAL_COLS-1 to 0, and increment the row counter on each wrap.
REQ-021 SHALL wrap the row counter at TOTAL_ROWS-1 to 0.
REQ-022 SHALL give frame-start reload priority over normal counting, so a mid-frame upstream restart realigns immediately.
REQ-023 SHALL drive sync low for input column c in [ACTIVE_COLS+H_FRONT_PORCH, ACTIVE_COLS+H_FRONT_PORCH+H_SYNC_WIDTH-1], which is 656..751 at defaults, and high otherwise.
REQ-024 SHALL drive sync low for input row r in [ACTIVE_ROWS+V_FRONT_PORCH, ACTIVE_ROWS+V_FRONT_PORCH+V_SYNC_WIDTH-1], which is 490..491 at defaults, and high otherwise.
REQ-025 SHALL register the sync and colour outputs with a fixed latency of 2 clocks from input sample to output, with colour and syncs mutually aligned.
REQ-026 SHALL set o_locked to 1 on the cycle after the first frame start and hold it at 1 until reset.
REQ-027 SHALL, while o_locked=0, hold o_hsync and o_vsync at 1 and hold o_red, o_grn and o_blu at 0.
REQ-028 SHALL size the counters to hold TOTAL_COLS-1 and TOTAL_ROWS-1 (10 bits at defaults) with no overflow beyond wrap.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear the column counter, row counter and o_locked to 0 and set r_vsync to 1, so that an i_vsync held high does not falsely lock.
REQ-030 SHALL, on reset, clear all pipeline registers so that on the next cycle o_hsync=1, o_vsync=1 and o_red=o_grn=o_blu=0.
REQ-031 SHALL, after reset mid-operation, keep o_locked at 0 until the next rising edge of i_vsync.

Configuration
REQ-032 SHALL, with macro VGA_PORCH_BLANK_EN defined, force the colour outputs to 0 whenever the sampled i_hsync or i_vsync was 0 (the 2-clock latency applies).
REQ-033 SHALL, without VGA_PORCH_BLANK_EN, pass the colour inputs through delayed by 2 clocks regardless of the active flags, subject only to REQ-027.

Verification
REQ-034 SHALL verify reset: assert rst for 3 cycles with any inputs -> o_hsync=1, o_vsync=1, colour=0 and o_locked=0 from the cycle after the first rst edge.
REQ-035 SHALL verify lock: first i_vsync rise at cycle T -> o_locked=1 at T+1, and the first o_hsync low appears at T+656+2 and lasts exactly 96 cycles.
REQ-036 SHALL verify vsync: over a full frame -> o_vsync is low for exactly 1600 consecutive cycles, starting 2 cycles after input row 490, column 0.
REQ-037 SHALL verify video with VGA_PORCH_BLANK_EN: i_red=3'b101 at column 639, row 0 -> o_red=3'b101 two cycles later; the same value at column 640 -> o_red=0.
REQ-038 SHALL verify restart: upstream frame restarted at row 200, column 300 -> counters reload and the next o_hsync falling edge occurs 656+2 cycles after the restart.
REQ-039 SHALL verify mid-frame reset: rst pulsed at row 100 -> o_locked=0 and syncs held high until the next i_vsync rise, after which REQ-035 timing holds.

Source files
------------

// File: rtl/vga_sync_porch.sv
// vga_sync_porch: regenerates VGA hsync/vsync from upstream active-area flags.
// Internal column/row counters lock onto the rising edge of i_vsync (the first
// active row of a frame). Sync and colour leave the block two clocks after
// sampling, mutually aligned. Outputs idle (syncs high, colour 0) until locked.
// Optional feature: define VGA_PORCH_BLANK_EN to force colour to 0 whenever
// the sampled i_hsync or i_vsync was low (porch / sync / vertical blanking).
module vga_sync_porch #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int VIDEO_WIDTH   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [VIDEO_WIDTH-1:0] i_red,
  input  logic [VIDEO_WIDTH-1:0] i_grn,
  input  logic [VIDEO_WIDTH-1:0] i_blu,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [VIDEO_WIDTH-1:0] o_red,
  output logic [VIDEO_WIDTH-1:0] o_grn,
  output logic [VIDEO_WIDTH-1:0] o_blu,
  output logic                   o_locked
);

  localparam int CW = (TOTAL_COLS > 1) ? $clog2(TOTAL_COLS) : 1;
  localparam int RW = (TOTAL_ROWS > 1) ? $clog2(TOTAL_ROWS) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);
  localparam logic [CW-1:0] HS_START = CW'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CW-1:0] HS_END   = CW'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [RW-1:0] VS_START = RW'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [RW-1:0] VS_END   = RW'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  logic          r_vsync;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          frame_start;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          hs_low;
  logic          vs_low;

  // Stage-1 pipeline registers
  logic                   valid_s1;
  logic                   hs_s1;
  logic                   vs_s1;
  logic [VIDEO_WIDTH-1:0] red_s1;
  logic [VIDEO_WIDTH-1:0] grn_s1;
  logic [VIDEO_WIDTH-1:0] blu_s1;
  logic [VIDEO_WIDTH-1:0] red_c;
  logic [VIDEO_WIDTH-1:0] grn_c;
  logic [VIDEO_WIDTH-1:0] blu_c;

  // The counters hold the position of the next sample, so the sample on a
  // frame-start cycle is column 0, row 0 regardless of the stored value.
  assign frame_start = i_vsync & ~r_vsync;
  assign cur_col     = frame_start ? '0 : col_cnt;
  assign cur_row     = frame_start ? '0 : row_cnt;
  assign hs_low      = (cur_col >= HS_START) && (cur_col <= HS_END);
  assign vs_low      = (cur_row >= VS_START) && (cur_row <= VS_END);

`ifdef VGA_PORCH_BLANK_EN
  // Blank colour outside the upstream active area.
  always_comb begin
    red_c = '0;
    grn_c = '0;
    blu_c = '0;
    if (i_hsync && i_vsync) begin
      red_c = i_red;
      grn_c = i_grn;
      blu_c = i_blu;
    end
  end
`else
  logic unused_hsync;
  assign unused_hsync = i_hsync;

  // Colour passes straight through; only the lock gate applies.
  always_comb begin
    red_c = i_red;
    grn_c = i_grn;
    blu_c = i_blu;
  end
`endif

  // Frame-start edge detect, position counters and lock flag.
  // r_vsync resets high so an i_vsync held high across reset cannot lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync  <= 1'b1;
      col_cnt  <= '0;
      row_cnt  <= '0;
      o_locked <= 1'b0;
    end else begin
      r_vsync <= i_vsync;
      if (frame_start) begin
        col_cnt  <= CW'(1);
        row_cnt  <= '0;
        o_locked <= 1'b1;
      end else if (col_cnt == COL_LAST) begin
        col_cnt <= '0;
        row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
      end else begin
        col_cnt <= col_cnt + 1'b1;
      end
    end
  end

  // Stage 1: decode sync levels and capture colour for the current sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_s1 <= 1'b0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      red_s1   <= '0;
      grn_s1   <= '0;
      blu_s1   <= '0;
    end else begin
      valid_s1 <= frame_start | o_locked;
      hs_s1    <= ~hs_low;
      vs_s1    <= ~vs_low;
      red_s1   <= red_c;
      grn_s1   <= grn_c;
      blu_s1   <= blu_c;
    end
  end

  // Stage 2: output registers, idle levels until the sample was locked.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_red   <= '0;
      o_grn   <= '0;
      o_blu   <= '0;
    end else if (valid_s1) begin
      o_hsync <= hs_s1;
      o_vsync <= vs_s1;
      o_red   <= red_s1;
      o_grn   <= grn_s1;
      o_blu   <= blu_s1;
    end else begin
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_red   <= '0;
      o_grn   <= '0;
      o_blu   <= '0;
    end
  end

endmodule

// File: tb/tb_vga_sync_porch.sv
// Testbench for vga_sync_porch. Horizontal timing uses the default 800-column
// line; the frame is shortened to 20 rows (10 active, front porch 5, sync 2)
// so whole frames fit in a short run while the vsync pulse stays 2 lines.
module tb_vga_sync_porch;

  localparam int TC  = 800;
  localparam int TR  = 20;
  localparam int AC  = 640;
  localparam int AR  = 10;
  localparam int HFP = 16;
  localparam int HSW = 96;
  localparam int VFP = 5;
  localparam int VSW = 2;
  localparam int VW  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_hsync = 1'b0;
  logic          i_vsync = 1'b0;
  logic [VW-1:0] i_red = '0;
  logic [VW-1:0] i_grn = '0;
  logic [VW-1:0] i_blu = '0;
  logic          o_hsync;
  logic          o_vsync;
  logic [VW-1:0] o_red;
  logic [VW-1:0] o_grn;
  logic [VW-1:0] o_blu;
  logic          o_locked;

  int n_checks = 0;
  int n_err    = 0;

  // Upstream model state
  bit gen_on  = 1'b0;
  bit idle_vs = 1'b0;
  int u_col   = 0;
  int u_row   = 0;
  int cyc     = 0;

  // Output statistics
  int win0, hs_first, hs_line, hs_total, hs_fall;
  int vs_first, vs_last, vs_total;
  int idle_viol = 0;
  bit prev_hs;

  vga_sync_porch #(
    .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .V_FRONT_PORCH(VFP),
    .V_SYNC_WIDTH(VSW), .VIDEO_WIDTH(VW)
  ) dut (
    .clk(clk), .rst(rst), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red(i_red), .i_grn(i_grn), .i_blu(i_blu),
    .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_red(o_red), .o_grn(o_grn), .o_blu(o_blu), .o_locked(o_locked)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    win0     = cyc;
    hs_first = -1;
    hs_line  = 0;
    hs_total = 0;
    hs_fall  = -1;
    vs_first = -1;
    vs_last  = -1;
    vs_total = 0;
    prev_hs  = o_hsync;
  endtask

  // Drive inputs for cycle cyc, clock them in, then observe outputs of cycle cyc+1.
  task automatic tick();
    if (gen_on) begin
      i_vsync = (u_row < AR);
      i_hsync = (u_col < AC);
      i_red   = ((u_col == AC - 1) || (u_col == AC)) ? 3'b101 : 3'(u_col & 7);
      i_grn   = 3'(u_row & 7);
      i_blu   = ~3'(u_col & 7);
    end else begin
      i_vsync = idle_vs;
      i_hsync = 1'($urandom_range(0, 1));
      i_red   = 3'($urandom_range(0, 7));
      i_grn   = 3'($urandom_range(0, 7));
      i_blu   = 3'($urandom_range(0, 7));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (gen_on) begin
      if (u_col == TC - 1) begin
        u_col = 0;
        u_row = (u_row == TR - 1) ? 0 : u_row + 1;
      end else begin
        u_col++;
      end
    end
    if (o_hsync === 1'b0) begin
      hs_total++;
      if (hs_first < 0) hs_first = cyc;
      if (cyc <= win0 + TC) hs_line++;
      if (prev_hs && hs_fall < 0) hs_fall = cyc;
    end
    prev_hs = (o_hsync === 1'b1);
    if (o_vsync === 1'b0) begin
      vs_total++;
      if (vs_first < 0) vs_first = cyc;
      vs_last = cyc;
    end
    if (o_locked === 1'b0 &&
        (o_hsync !== 1'b1 || o_vsync !== 1'b1 || o_red !== 0 || o_grn !== 0 || o_blu !== 0))
      idle_viol++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  // Advance the upstream until it is about to present (row, col); bounded.
  task automatic wait_pos(input string tag, input int row, input int col);
    int n = 0;
    while (!(u_row == row && u_col == col) && n < 20000) begin
      tick();
      n++;
    end
    if (n >= 20000) check(tag, 0, 1);
  endtask

  initial begin
    int t0, r0, t2, lk_seen, sync_low;

    // Reset held 3 cycles with i_vsync high and random colour.
    gen_on  = 1'b0;
    idle_vs = 1'b1;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_hsync",  o_hsync,  1);
      check("rst_vsync",  o_vsync,  1);
      check("rst_colour", {o_red, o_grn, o_blu}, 0);
      check("rst_locked", o_locked, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("no_false_lock", o_locked, 0);
    check("unlocked_hsync", o_hsync, 1);
    idle_vs = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // First frame: lock, line timing, colour path, vsync over the full frame.
    gen_on = 1'b1;
    u_col  = 0;
    u_row  = 0;
    t0     = cyc;
    clear_stats();
    check("pre_lock", o_locked, 0);
    tick();
    check("lock_t1", o_locked, 1);
    run_to(t0 + 2);
    check("red_c0", o_red, 0);
    check("blu_c0", o_blu, 7);
    run_to(t0 + 7);
    check("red_c5", o_red, 5);
    check("blu_c5", o_blu, 2);
    run_to(t0 + AC - 1 + 2);
    check("red_c639", o_red, 3'b101);
    run_to(t0 + AC + 2);
`ifdef VGA_PORCH_BLANK_EN
    check("red_c640", o_red, 0);
`else
    check("red_c640", o_red, 3'b101);
`endif
    run_to(t0 + 3 * TC + 10 + 2);
    check("grn_r3", o_grn, 3);
    check("red_r3c10", o_red, 2);
    run_to(t0 + TR * TC + 1);
    check("hs_first", hs_first, t0 + 658);
    check("hs_width", hs_line, 96);
    check("hs_frame_total", hs_total, 96 * TR);
    check("vs_first", vs_first, t0 + (AR + VFP) * TC + 2);
    check("vs_last", vs_last, t0 + (AR + VFP) * TC + 2 + 1599);
    check("vs_total", vs_total, 1600);

    // Upstream restart from vertical blanking (row 12, column 300).
    wait_pos("wait_restart", 12, 300);
    u_row = 0;
    u_col = 0;
    r0    = cyc;
    clear_stats();
    run_to(r0 + 900);
    check("restart_hs_fall", hs_fall, r0 + 658);
    check("restart_locked", o_locked, 1);

    // Reset pulsed mid-frame at row 5 while i_vsync is high.
    wait_pos("wait_mid", 5, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_locked", o_locked, 0);
    check("mid_rst_hsync", o_hsync, 1);
    check("mid_rst_vsync", o_vsync, 1);
    check("mid_rst_red", o_red, 0);
    lk_seen  = 0;
    sync_low = 0;
    for (int n = 0; n < 20000 && !(u_row == 0 && u_col == 0); n++) begin
      tick();
      if (o_locked !== 1'b0) lk_seen++;
      if (o_hsync !== 1'b1 || o_vsync !== 1'b1) sync_low++;
    end
    check("mid_no_lock", lk_seen, 0);
    check("mid_sync_idle", sync_low, 0);
    check("mid_reached_rise", (u_row == 0 && u_col == 0), 1);
    t2 = cyc;
    clear_stats();
    check("relock_pre", o_locked, 0);
    tick();
    check("relock_t1", o_locked, 1);
    run_to(t2 + TC);
    check("relock_hs_first", hs_first, t2 + 658);
    check("relock_hs_width", hs_line, 96);

    check("idle_while_unlocked", idle_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
